cdb_rr_buffered: RTL and testbench

Parametrised common data bus for the out-of-order core. Each functional unit (FU) completes into a private one-entry holding slot using a valid/ready handshake. A round-robin arbiter picks up to N occupied slots per cycle and drives N registered broadcast lanes to the RS, map table and ROB. Compared with the fixed-priority combinational bus, this block adds fairness, buffering, registered outputs and flush.

---
 rtl/cdb_rr_buffered_pkg.sv | 34 +++
 rtl/cdb_rr_buffered_if.sv | 33 +++
 rtl/cdb_rr_buffered_rr_multi_sel.sv | 46 ++++
 rtl/cdb_rr_buffered.sv | 124 ++++++++++++
 tb/tb_cdb_rr_buffered.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/cdb_rr_buffered_pkg.sv
// Shared types for the buffered round-robin common data bus: FU result
// packets, CDB broadcast packets and the default lane/requester counts.
package cdb_rr_buffered_pkg;

    localparam int NUM_FU_ALU   = 2;
    localparam int NUM_FU_MULT  = 1;
    localparam int NUM_FU_LOAD  = 1;
    localparam int NUM_FU_STORE = 0;
    localparam int NUM_FU_DEF   = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD + NUM_FU_STORE;
    localparam int CDB_N_DEF    = 2;

    typedef logic [4:0]  REG_IDX;
    typedef logic [5:0]  PHYS_REG_IDX;
    typedef logic [31:0] DATA;

    typedef struct packed {
        REG_IDX      reg_idx;
        PHYS_REG_IDX p_reg_idx;
        DATA         reg_val;
    } FU_PACKET;

    typedef struct packed {
        logic        valid;
        REG_IDX      reg_idx;
        PHYS_REG_IDX p_reg_idx;
        DATA         reg_val;
    } CDB_PACKET;

    // Pointer width never drops below one bit, even with a single requester.
    function automatic int ptr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cdb_rr_buffered_if.sv
// FU-side handshake and broadcast lanes of the common data bus.
// master: the FU/consumer side; slave: the CDB itself.
interface cdb_rr_buffered_if
    import cdb_rr_buffered_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_DEF,
    parameter int N      = CDB_N_DEF,
    parameter int PTR_W  = ptr_width(NUM_FU)
) ();

    logic      [NUM_FU-1:0] fu_valid;
    FU_PACKET  [NUM_FU-1:0] fu_packet;
    logic      [NUM_FU-1:0] fu_ready;
    CDB_PACKET [N-1:0]      entries;
    logic      [PTR_W-1:0]  rr_ptr_o;

    modport master (
        output fu_valid,
        output fu_packet,
        input  fu_ready,
        input  entries,
        input  rr_ptr_o
    );

    modport slave (
        input  fu_valid,
        input  fu_packet,
        output fu_ready,
        output entries,
        output rr_ptr_o
    );

endinterface

// File: rtl/cdb_rr_buffered_rr_multi_sel.sv
// Combinational multi-grant round-robin selector. Scans requesters starting
// at i_ptr (wrapping) and hands the first N hits to lanes 0..N-1 in order.
module cdb_rr_buffered_rr_multi_sel
    import cdb_rr_buffered_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_DEF,
    parameter int N      = CDB_N_DEF,
    parameter int PTR_W  = ptr_width(NUM_FU)
) (
    input  logic [NUM_FU-1:0]        i_req,
    input  logic [PTR_W-1:0]         i_ptr,
    output logic [NUM_FU-1:0]        o_gnt,
    output logic [N-1:0][NUM_FU-1:0] o_gnt_bus,
    output logic [PTR_W-1:0]         o_last_idx,
    output logic                     o_any
);

    // Rotating scan; requester index compared against constant loop indices
    // so no variable bit-selects are needed.
    always_comb begin
        int w_idx;
        int w_cnt;
        o_gnt      = '0;
        o_gnt_bus  = '0;
        o_last_idx = '0;
        o_any      = 1'b0;
        w_idx      = 0;
        w_cnt      = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_idx = int'(i_ptr) + i;
            if (w_idx >= NUM_FU) w_idx = w_idx - NUM_FU;
            for (int j = 0; j < NUM_FU; j++) begin
                if (j == w_idx && i_req[j] && w_cnt < N) begin
                    o_gnt[j] = 1'b1;
                    for (int k = 0; k < N; k++) begin
                        if (k == w_cnt) o_gnt_bus[k][j] = 1'b1;
                    end
                    o_last_idx = PTR_W'(j);
                    o_any      = 1'b1;
                    w_cnt      = w_cnt + 1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_rr_buffered.sv
// Buffered round-robin common data bus. Each FU completes into a one-entry
// slot; up to N occupied slots per cycle are granted and broadcast on
// registered lanes, packed from lane 0 upward. Flush squashes slots and lanes.
// Optional build macro CDB_STATS_EN adds saturating broadcast/stall counters.
module cdb_rr_buffered
    import cdb_rr_buffered_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_DEF,
    parameter int N      = CDB_N_DEF,
    parameter int PTR_W  = ptr_width(NUM_FU)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    cdb_rr_buffered_if.slave bus
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]      stat_bcast,
    output logic [31:0]      stat_stall
`endif
);

    logic      [NUM_FU-1:0]        r_slot_occ;
    FU_PACKET  [NUM_FU-1:0]        r_slot_pkt;
    logic      [PTR_W-1:0]         r_ptr;

    logic      [NUM_FU-1:0]        w_gnt;
    logic      [N-1:0][NUM_FU-1:0] w_gnt_bus;
    logic      [PTR_W-1:0]         w_last;
    logic                          w_any;
    logic      [PTR_W-1:0]         w_ptr_next;
    CDB_PACKET [N-1:0]             w_lane;

    // A slot drained this cycle can be refilled at the same edge.
    assign bus.fu_ready = {NUM_FU{~flush}} & (~r_slot_occ | w_gnt);
    assign bus.rr_ptr_o = r_ptr;

    cdb_rr_buffered_rr_multi_sel #(
        .NUM_FU (NUM_FU),
        .N      (N),
        .PTR_W  (PTR_W)
    ) u_sel (
        .i_req      (r_slot_occ),
        .i_ptr      (r_ptr),
        .o_gnt      (w_gnt),
        .o_gnt_bus  (w_gnt_bus),
        .o_last_idx (w_last),
        .o_any      (w_any)
    );

    // Lane mux: valid comes from the grant alone, never from the payload.
    always_comb begin
        w_lane = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < NUM_FU; j++) begin
                if (w_gnt_bus[k][j]) begin
                    w_lane[k].valid     = 1'b1;
                    w_lane[k].reg_idx   = r_slot_pkt[j].reg_idx;
                    w_lane[k].p_reg_idx = r_slot_pkt[j].p_reg_idx;
                    w_lane[k].reg_val   = r_slot_pkt[j].reg_val;
                end
            end
        end
    end

    // Next pointer is one past the last granted FU, wrapping to 0.
    always_comb begin
        w_ptr_next = (w_last == PTR_W'(NUM_FU - 1)) ? '0 : w_last + PTR_W'(1);
    end

    // Slots, lane registers and pointer; flush behaves exactly like reset.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_slot_occ  <= '0;
            r_slot_pkt  <= '0;
            bus.entries <= '0;
            r_ptr       <= '0;
        end else begin
            for (int j = 0; j < NUM_FU; j++) begin
                if (bus.fu_valid[j] && bus.fu_ready[j]) begin
                    r_slot_occ[j] <= 1'b1;
                    r_slot_pkt[j] <= bus.fu_packet[j];
                end else if (w_gnt[j]) begin
                    r_slot_occ[j] <= 1'b0;
                end
            end
            bus.entries <= w_lane;
            if (w_any) r_ptr <= w_ptr_next;
        end
    end

`ifdef CDB_STATS_EN
    logic [31:0] r_stat_bcast;
    logic [31:0] r_stat_stall;
    logic [31:0] w_bcast_n;
    logic [32:0] w_bcast_sum;
    logic        w_stall;

    // Count lanes actually broadcast this cycle and detect any refused FU.
    always_comb begin
        w_bcast_n = '0;
        for (int k = 0; k < N; k++) begin
            w_bcast_n = w_bcast_n + 32'(bus.entries[k].valid);
        end
        w_bcast_sum = {1'b0, r_stat_bcast} + {1'b0, w_bcast_n};
        w_stall     = |(bus.fu_valid & ~bus.fu_ready);
    end

    // Saturating counters; only reset clears them, flush does not.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_bcast <= '0;
            r_stat_stall <= '0;
        end else begin
            r_stat_bcast <= w_bcast_sum[32] ? '1 : w_bcast_sum[31:0];
            if (w_stall && (r_stat_stall != '1)) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_bcast = r_stat_bcast;
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_cdb_rr_buffered.sv
// Bench for cdb_rr_buffered with NUM_FU=4, N=2. Each FU tags its packets with
// reg_idx = FU index; per-FU expected queues hold accepted packets in order.
module tb_cdb_rr_buffered;
    import cdb_rr_buffered_pkg::*;

    localparam int NFU = 4;
    localparam int NL  = 2;
    localparam int PW  = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    cdb_rr_buffered_if #(.NUM_FU(NFU), .N(NL), .PTR_W(PW)) bus ();

`ifdef CDB_STATS_EN
    logic [31:0] stat_bcast;
    logic [31:0] stat_stall;
`endif

    cdb_rr_buffered #(.NUM_FU(NFU), .N(NL), .PTR_W(PW)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
`ifdef CDB_STATS_EN
        ,
        .stat_bcast (stat_bcast),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       fl;
        logic [3:0] v;
        logic       cr;
        logic [3:0] er;
        logic       chk;
        logic       l0v;
        int         l0f;
        logic       l1v;
        int         l1f;
        int         ptr;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    FU_PACKET   cur [NFU];
    FU_PACKET   q   [NFU][$];
    logic [5:0] seq = 6'd1;
    vec_t       tv  [13];

    function automatic vec_t mk(logic rst, logic fl, logic [3:0] v, logic cr, logic [3:0] er,
                                logic chk, logic l0v, int l0f, logic l1v, int l1f, int ptr);
        vec_t t;
        t.rst = rst; t.fl = fl; t.v = v; t.cr = cr; t.er = er; t.chk = chk;
        t.l0v = l0v; t.l0f = l0f; t.l1v = l1v; t.l1f = l1f; t.ptr = ptr;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic newpkt(int j);
        cur[j].reg_idx   = 5'(j);
        cur[j].p_reg_idx = seq;
        cur[j].reg_val   = $urandom;
        seq              = seq + 6'd1;
    endtask

    // Match a broadcast lane against the oldest accepted packet of its FU.
    task automatic sb_pop(int k, string tag);
        FU_PACKET e;
        int fu;
        fu = int'(bus.entries[k].reg_idx);
        if (fu >= NFU || q[fu].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s lane%0d unexpected broadcast: got fu %0d expected none", tag, k, fu);
        end else begin
            e = q[fu].pop_front();
            chk($sformatf("%s lane%0d p_reg_idx", tag, k), 32'(bus.entries[k].p_reg_idx), 32'(e.p_reg_idx));
            chk($sformatf("%s lane%0d reg_val", tag, k), bus.entries[k].reg_val, e.reg_val);
        end
    endtask

    // One clock cycle: drive after the edge, check mid-cycle.
    task automatic run(vec_t t, string tag);
        @(posedge clock);
        #1;
        reset        = t.rst;
        flush        = t.fl;
        bus.fu_valid = t.v;
        for (int j = 0; j < NFU; j++) bus.fu_packet[j] = cur[j];
        @(negedge clock);
        if (t.cr) chk({tag, " ready"}, 32'(bus.fu_ready), 32'(t.er));
        if (t.chk) begin
            chk({tag, " l0 valid"}, 32'(bus.entries[0].valid), 32'(t.l0v));
            if (t.l0v) chk({tag, " l0 fu"}, 32'(bus.entries[0].reg_idx), 32'(t.l0f));
            chk({tag, " l1 valid"}, 32'(bus.entries[1].valid), 32'(t.l1v));
            if (t.l1v) chk({tag, " l1 fu"}, 32'(bus.entries[1].reg_idx), 32'(t.l1f));
            chk({tag, " rr_ptr"}, 32'(bus.rr_ptr_o), 32'(t.ptr));
            if (t.rst) begin
                checks++;
                if (bus.entries !== '0) begin
                    errors++;
                    $display("FAIL %s entries: got %h expected 0", tag, bus.entries);
                end
            end
        end
        if (!t.rst) begin
            for (int k = 0; k < NL; k++) begin
                if (bus.entries[k].valid === 1'b1) sb_pop(k, tag);
            end
        end
        if (!t.rst && !t.fl) begin
            for (int j = 0; j < NFU; j++) begin
                if (t.v[j] && t.er[j]) begin
                    q[j].push_back(cur[j]);
                    newpkt(j);
                end
            end
        end
        if (t.rst || t.fl) begin
            for (int j = 0; j < NFU; j++) q[j].delete();
        end
    endtask

    initial begin
        bus.fu_valid = '0;
        for (int j = 0; j < NFU; j++) newpkt(j);
        for (int j = 0; j < NFU; j++) bus.fu_packet[j] = cur[j];

        // reset held two cycles with all FUs valid, then release
        tv[0]  = mk(1, 0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(1, 0, 4'b1111, 0, 4'b0000, 1, 0, 0, 0, 0, 0);
        tv[2]  = mk(0, 0, 4'b0000, 1, 4'b1111, 1, 0, 0, 0, 0, 0);
        tv[3]  = mk(0, 0, 4'b0000, 1, 4'b1111, 1, 0, 0, 0, 0, 0);
        // saturation: alternate {0,1} and {2,3}
        tv[4]  = mk(0, 0, 4'b1111, 1, 4'b1111, 1, 0, 0, 0, 0, 0);
        tv[5]  = mk(0, 0, 4'b1111, 1, 4'b0011, 1, 0, 0, 0, 0, 0);
        tv[6]  = mk(0, 0, 4'b1111, 1, 4'b1100, 1, 1, 0, 1, 1, 2);
        tv[7]  = mk(0, 0, 4'b1111, 1, 4'b0011, 1, 1, 2, 1, 3, 0);
        tv[8]  = mk(0, 0, 4'b1111, 1, 4'b1100, 1, 1, 0, 1, 1, 2);
        tv[9]  = mk(0, 0, 4'b1111, 1, 4'b0011, 1, 1, 2, 1, 3, 0);
        // flush with all slots full, then nothing stale afterwards
        tv[10] = mk(0, 1, 4'b1111, 1, 4'b0000, 1, 1, 0, 1, 1, 2);
        tv[11] = mk(0, 0, 4'b0000, 1, 4'b1111, 1, 0, 0, 0, 0, 0);
        tv[12] = mk(0, 0, 4'b0000, 1, 4'b1111, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 13; i++) run(tv[i], $sformatf("vec%0d", i));

        // single request with zero payload on FU2
        cur[2].p_reg_idx = 6'd7;
        cur[2].reg_val   = 32'd0;
        run(mk(0, 0, 4'b0100, 1, 4'b1111, 1, 0, 0, 0, 0, 0), "single0");
        run(mk(0, 0, 4'b0000, 1, 4'b1111, 1, 0, 0, 0, 0, 0), "single1");
        run(mk(0, 0, 4'b0000, 1, 4'b1111, 1, 1, 2, 0, 0, 3), "single2");
        chk("single p_reg_idx", 32'(bus.entries[0].p_reg_idx), 32'd7);
        chk("single reg_val", bus.entries[0].reg_val, 32'd0);

        // pointer wrap: ptr=3, slots 3 and 0
        run(mk(0, 0, 4'b1001, 1, 4'b1111, 1, 0, 0, 0, 0, 3), "wrap0");
        run(mk(0, 0, 4'b0000, 1, 4'b1111, 1, 0, 0, 0, 0, 3), "wrap1");
        run(mk(0, 0, 4'b0000, 1, 4'b1111, 1, 1, 3, 1, 0, 1), "wrap2");

        // backpressure on FU2 while its slot waits behind FU0/FU1
        run(mk(0, 1, 4'b0000, 1, 4'b0000, 1, 0, 0, 0, 0, 1), "bp_flush");
        run(mk(0, 0, 4'b0111, 1, 4'b1111, 1, 0, 0, 0, 0, 0), "bp0");
        run(mk(0, 0, 4'b0100, 1, 4'b1011, 1, 0, 0, 0, 0, 0), "bp1");
        run(mk(0, 0, 4'b0100, 1, 4'b1111, 1, 1, 0, 1, 1, 2), "bp2");
        run(mk(0, 0, 4'b0000, 1, 4'b1111, 1, 1, 2, 0, 0, 3), "bp3");
        run(mk(0, 0, 4'b0000, 1, 4'b1111, 1, 1, 2, 0, 0, 3), "bp4");
        run(mk(0, 0, 4'b0000, 1, 4'b1111, 1, 0, 0, 0, 0, 3), "bp5");

        for (int j = 0; j < NFU; j++) begin
            chk($sformatf("pending fu%0d", j), 32'(q[j].size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
